player_input_decoder: RTL and testbench

- Converts the PS/2 scan-code byte stream into the level-type movement and shoot controls consumed by the player physics block: up, down, left, right, shoot.
- Tracks make/break state of WASD, arrow keys and Space in the system clock domain.
- Presents the decoded controls as per-frame snapshots so the player block sees stable inputs for a whole frame.
- Latches short Space taps so a press and release between two frame updates still fires one shot.

---
 rtl/player_input_decoder.sv | 109 ++++++++++
 tb/tb_player_input_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/player_input_decoder.sv
// PS/2 scan-code decoder for the player block: tracks WASD/arrow/Space make/break
// state and presents per-frame snapshots of up/down/left/right/shoot.
module player_input_decoder #(
  parameter bit STICKY_SHOOT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] code,
  input  logic       code_valid,
  input  logic       frame_tick,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       shoot,
  output logic [8:0] keys_held,
  output logic [1:0] dbg_state,
  output logic       dbg_shoot_sticky
);

  // Handshake: code_valid is a one-cycle strobe with no back-pressure; every
  // strobed byte is consumed in the cycle it is presented.
  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

  state_t     state, state_next;
  logic [8:0] key_set, key_clr;
  logic       shoot_sticky;

  function automatic logic [8:0] normal_map(input logic [7:0] c);
    case (c)
      8'h1D:   return 9'h001;
      8'h1C:   return 9'h002;
      8'h1B:   return 9'h004;
      8'h23:   return 9'h008;
      8'h29:   return 9'h010;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] ext_map(input logic [7:0] c);
    case (c)
      8'h75:   return 9'h020;
      8'h72:   return 9'h040;
      8'h6B:   return 9'h080;
      8'h74:   return 9'h100;
      default: return 9'h000;
    endcase
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // E0 always restarts an extended sequence; F0 always (re)enters a break state.
  always_comb begin
    state_next = state;
    key_set    = '0;
    key_clr    = '0;
    if (code_valid) begin
      if (code == 8'hE0) begin
        state_next = EXT;
      end else if (code == 8'hF0) begin
        state_next = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        state_next = IDLE;
        case (state)
          IDLE:    key_set = normal_map(code);
          EXT:     key_set = ext_map(code);
          BRK:     key_clr = normal_map(code);
          EXT_BRK: key_clr = ext_map(code);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) keys_held <= '0;
    else        keys_held <= (keys_held | key_set) & ~key_clr;
  end

  // A Space make in the tick cycle must survive the tick's clear.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)          shoot_sticky <= 1'b0;
    else if (key_set[4]) shoot_sticky <= 1'b1;
    else if (frame_tick) shoot_sticky <= 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      up    <= 1'b0;
      down  <= 1'b0;
      left  <= 1'b0;
      right <= 1'b0;
      shoot <= 1'b0;
    end else if (frame_tick) begin
      up    <= keys_held[0] | keys_held[5];
      down  <= keys_held[2] | keys_held[6];
      left  <= keys_held[1] | keys_held[7];
      right <= keys_held[3] | keys_held[8];
      shoot <= keys_held[4] | (STICKY_SHOOT & shoot_sticky);
    end
  end

  assign dbg_state        = state;
  assign dbg_shoot_sticky = shoot_sticky;

endmodule

// File: tb/tb_player_input_decoder.sv
// Scoreboard bench: two decoders (sticky on/off) share stimulus; expected frame
// outputs are queued at each tick and checked by a monitor on the following cycle.
module tb_player_input_decoder;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] code = '0;
  logic       code_valid = 1'b0;
  logic       frame_tick = 1'b0;

  logic       up_a, down_a, left_a, right_a, shoot_a, sticky_a;
  logic       up_b, down_b, left_b, right_b, shoot_b, sticky_b;
  logic [8:0] keys_a, keys_b;
  logic [1:0] state_a, state_b;

  logic [9:0] exp_q[$];
  logic [9:0] last_exp = '0;
  logic       tick_d;
  int         checks = 0;
  int         failures = 0;

  player_input_decoder #(.STICKY_SHOOT(1'b1)) u_a (
    .Clk(Clk), .Reset(Reset), .code(code), .code_valid(code_valid), .frame_tick(frame_tick),
    .up(up_a), .down(down_a), .left(left_a), .right(right_a), .shoot(shoot_a),
    .keys_held(keys_a), .dbg_state(state_a), .dbg_shoot_sticky(sticky_a)
  );

  player_input_decoder #(.STICKY_SHOOT(1'b0)) u_b (
    .Clk(Clk), .Reset(Reset), .code(code), .code_valid(code_valid), .frame_tick(frame_tick),
    .up(up_b), .down(down_b), .left(left_b), .right(right_b), .shoot(shoot_b),
    .keys_held(keys_b), .dbg_state(state_b), .dbg_shoot_sticky(sticky_b)
  );

  // Clock and reset-aware tick delay
  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) tick_d <= 1'b0;
    else        tick_d <= frame_tick;
  end

  function automatic logic [9:0] mk(bit u, bit d, bit l, bit r, bit sa, bit sb);
    return {u, d, l, r, sa, u, d, l, r, sb};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a new frame value appears the cycle after a tick; otherwise outputs hold.
  always @(negedge Clk) begin
    if (Reset) begin
      if (tick_d) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected actual=output_update required=none_queued");
        end else begin
          last_exp = exp_q.pop_front();
        end
      end
      checks++;
      if ({up_a, down_a, left_a, right_a, shoot_a, up_b, down_b, left_b, right_b, shoot_b} !== last_exp) begin
        failures++;
        $display("FAIL frame_outputs actual=%b required=%b",
                 {up_a, down_a, left_a, right_a, shoot_a, up_b, down_b, left_b, right_b, shoot_b}, last_exp);
      end
    end
  end

  // Driver tasks: inputs change #1 after the rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    code = b;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  task automatic tick(input logic [9:0] e);
    frame_tick = 1'b1;
    exp_q.push_back(e);
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic send_tick(input logic [7:0] b, input logic [9:0] e);
    code = b;
    code_valid = 1'b1;
    frame_tick = 1'b1;
    exp_q.push_back(e);
    step();
    code_valid = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    // Reset state
    Reset = 1'b0;
    repeat (3) step();
    chk("reset_keys", 32'(keys_a), 32'h0);
    chk("reset_state", 32'(state_a), 32'h0);
    chk("reset_outs", 32'({up_a, down_a, left_a, right_a, shoot_a}), 32'h0);
    Reset = 1'b1;
    step();
    repeat (3) tick(mk(0, 0, 0, 0, 0, 0));
    chk("idle_keys", 32'(keys_a), 32'h0);
    chk("idle_state", 32'(state_a), 32'h0);

    // Arrow up make/break
    send(8'hE0);
    chk("ext_state", 32'(state_a), 32'h1);
    chk("up_before_75", 32'(keys_a[5]), 32'h0);
    send(8'h75);
    chk("up_make_latency", 32'(keys_a[5]), 32'h1);
    chk("after_make_state", 32'(state_a), 32'h0);
    tick(mk(1, 0, 0, 0, 0, 0));
    send(8'hE0);
    send(8'hF0);
    chk("ext_brk_state", 32'(state_a), 32'h3);
    chk("up_held_before_brk", 32'(keys_a[5]), 32'h1);
    send(8'h75);
    chk("up_break_latency", 32'(keys_a[5]), 32'h0);
    tick(mk(0, 0, 0, 0, 0, 0));

    // Space tap between ticks
    send(8'h29);
    chk("space_tap_held", 32'(keys_a[4]), 32'h1);
    send(8'hF0);
    send(8'h29);
    chk("space_tap_released", 32'(keys_a[4]), 32'h0);
    chk("sticky_set", 32'(sticky_a), 32'h1);
    tick(mk(0, 0, 0, 0, 1, 0));
    chk("sticky_cleared", 32'(sticky_a), 32'h0);
    tick(mk(0, 0, 0, 0, 0, 0));

    // Space make coinciding with a tick
    send_tick(8'h29, mk(0, 0, 0, 0, 0, 0));
    chk("coincide_keys", 32'(keys_a[4]), 32'h1);
    chk("coincide_sticky", 32'(sticky_a), 32'h1);
    send(8'hF0);
    send(8'h29);
    step();
    tick(mk(0, 0, 0, 0, 1, 0));
    chk("coincide_sticky_clr", 32'(sticky_a), 32'h0);

    // Left and right together, then ignored sequences
    send(8'h1C);
    send(8'hE0);
    send(8'h74);
    chk("lr_keys", 32'(keys_a), 32'h102);
    tick(mk(0, 0, 1, 1, 0, 0));
    send(8'hE0);
    send(8'h1D);
    send(8'hAA);
    send(8'hE1);
    send(8'h14);
    chk("ignored_keys", 32'(keys_a), 32'h102);
    chk("ignored_state", 32'(state_a), 32'h0);
    send(8'h1D);
    send(8'h1B);
    send(8'hE0);
    send(8'h72);
    send(8'h1D);
    chk("all_dirs_keys", 32'(keys_a), 32'h147);
    tick(mk(1, 1, 1, 1, 0, 0));
    send(8'hF0);
    send(8'hE0);
    send(8'h75);
    chk("brk_restart_keys", 32'(keys_a), 32'h167);
    send(8'h75);
    chk("normal_75_ignored", 32'(keys_a), 32'h167);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hF0); send(8'h1D);
    send(8'hF0); send(8'h1B);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("all_released", 32'(keys_a), 32'h0);
    tick(mk(0, 0, 0, 0, 0, 0));

    // Reset mid-sequence
    send(8'hE0);
    send(8'hF0);
    chk("pre_reset_state", 32'(state_a), 32'h3);
    Reset = 1'b0;
    #1;
    chk("async_reset_state", 32'(state_a), 32'h0);
    repeat (2) step();
    Reset = 1'b1;
    step();
    send(8'h75);
    chk("post_reset_keys", 32'(keys_a), 32'h0);
    chk("post_reset_state", 32'(state_a), 32'h0);
    tick(mk(0, 0, 0, 0, 0, 0));

    repeat (3) step();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
